// File: rtl/tqvp_prism_incond.sv
// Input conditioning for the PRISM controller: per-channel inversion, prescaled
// glitch filter, edge pulses, sticky edge flags and a level interrupt.
module tqvp_prism_incond #(
   parameter int CHANNELS = 8,
   parameter int FILT_W   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          ui_in,
   input  logic [5:0]          address,
   input  logic [31:0]         data_in,
   input  logic [1:0]          data_write_n,
   input  logic [1:0]          data_read_n,
   output logic [31:0]         data_out,
   output logic                data_ready,
   output logic [CHANNELS-1:0] cond_level,
   output logic [CHANNELS-1:0] cond_rise,
   output logic [CHANNELS-1:0] cond_fall,
   output logic                irq
);

   localparam logic [5:0] ADDR_CTRL   = 6'h30;
   localparam logic [5:0] ADDR_STATUS = 6'h34;
   localparam logic [5:0] ADDR_IRQEN  = 6'h38;

   logic [CHANNELS-1:0] enable_r;
   logic [CHANNELS-1:0] invert_r;
   logic [FILT_W-1:0]   thresh_r;
   logic [3:0]          div_r;
   logic [CHANNELS-1:0] rise_en_r;
   logic [CHANNELS-1:0] fall_en_r;
   logic [CHANNELS-1:0] rise_sticky_r;
   logic [CHANNELS-1:0] fall_sticky_r;
   logic [14:0]         pre_r;
   logic                irq_r;

   logic [CHANNELS-1:0] level_r;
   logic [CHANNELS-1:0] rise_r;
   logic [CHANNELS-1:0] fall_r;
   logic [FILT_W-1:0]   cnt_r [CHANNELS];

   logic [CHANNELS-1:0] level_nx_s;
   logic [CHANNELS-1:0] rise_nx_s;
   logic [CHANNELS-1:0] fall_nx_s;
   logic [FILT_W-1:0]   cnt_nx_s [CHANNELS];

   logic                wr_s;
   logic                ctrl_wr_s;
   logic                status_wr_s;
   logic                irqen_wr_s;
   logic [14:0]         mask_s;
   logic                tick_s;
   logic [FILT_W-1:0]   thresh_m1_s;
   logic [CHANNELS-1:0] raw_s;
   logic [CHANNELS-1:0] rise_clr_s;
   logic [CHANNELS-1:0] fall_clr_s;
   logic [31:0]         rd_ctrl_s;
   logic [31:0]         rd_status_s;
   logic [31:0]         rd_irqen_s;
   logic                unused_s;

   assign wr_s        = (data_write_n == 2'b10);
   assign ctrl_wr_s   = wr_s && (address == ADDR_CTRL);
   assign status_wr_s = wr_s && (address == ADDR_STATUS);
   assign irqen_wr_s  = wr_s && (address == ADDR_IRQEN);

   // With div=15 the shift wraps to zero, so the mask becomes all ones.
   assign mask_s = (15'h0001 << div_r) - 15'h0001;
   assign tick_s = ((pre_r & mask_s) == mask_s);

   assign raw_s      = ui_in[CHANNELS-1:0] ^ invert_r;
   assign rise_clr_s = status_wr_s ? data_in[8 +: CHANNELS]  : {CHANNELS{1'b0}};
   assign fall_clr_s = status_wr_s ? data_in[16 +: CHANNELS] : {CHANNELS{1'b0}};

   assign data_ready = 1'b1;
   assign cond_level = level_r;
   assign cond_rise  = rise_r;
   assign cond_fall  = fall_r;
   assign irq        = irq_r;
   assign unused_s   = &{1'b0, data_read_n, data_in, ui_in};

   // Effective threshold minus one; a programmed threshold of zero acts as one.
   always_comb begin
      thresh_m1_s = {FILT_W{1'b0}};
      if (thresh_r == {FILT_W{1'b0}}) begin
         thresh_m1_s = {FILT_W{1'b0}};
      end else begin
         thresh_m1_s = thresh_r - FILT_W'(1);
      end
   end

   // Per-channel stability filter and edge detection.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         level_nx_s[i] = level_r[i];
         cnt_nx_s[i]   = cnt_r[i];
         rise_nx_s[i]  = 1'b0;
         fall_nx_s[i]  = 1'b0;
         if (!enable_r[i]) begin
            level_nx_s[i] = 1'b0;
            cnt_nx_s[i]   = {FILT_W{1'b0}};
         end else if (raw_s[i] == level_r[i]) begin
            cnt_nx_s[i] = {FILT_W{1'b0}};
         end else if (tick_s) begin
            if (cnt_r[i] == thresh_m1_s) begin
               level_nx_s[i] = raw_s[i];
               cnt_nx_s[i]   = {FILT_W{1'b0}};
               rise_nx_s[i]  = raw_s[i];
               fall_nx_s[i]  = ~raw_s[i];
            end else begin
               cnt_nx_s[i] = cnt_r[i] + FILT_W'(1);
            end
         end else begin
            cnt_nx_s[i] = cnt_r[i];
         end
      end
   end

   // Filter state, pulses, stickies and interrupt registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_r       <= {CHANNELS{1'b0}};
         rise_r        <= {CHANNELS{1'b0}};
         fall_r        <= {CHANNELS{1'b0}};
         rise_sticky_r <= {CHANNELS{1'b0}};
         fall_sticky_r <= {CHANNELS{1'b0}};
         irq_r         <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_r[i] <= {FILT_W{1'b0}};
         end
      end else begin
         level_r       <= level_nx_s;
         rise_r        <= rise_nx_s;
         fall_r        <= fall_nx_s;
         // Set has priority over a simultaneous write-one-to-clear.
         rise_sticky_r <= (rise_sticky_r & ~rise_clr_s) | rise_nx_s;
         fall_sticky_r <= (fall_sticky_r & ~fall_clr_s) | fall_nx_s;
         irq_r         <= |((rise_sticky_r & rise_en_r) | (fall_sticky_r & fall_en_r));
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_r[i] <= cnt_nx_s[i];
         end
      end
   end

   // Prescaler: free-running, restarted by any CTRL write to align tick phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_r <= 15'h0000;
      end else if (ctrl_wr_s) begin
         pre_r <= 15'h0000;
      end else begin
         pre_r <= pre_r + 15'h0001;
      end
   end

   // Configuration registers; only 32-bit writes are accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_r  <= {CHANNELS{1'b0}};
         invert_r  <= {CHANNELS{1'b0}};
         thresh_r  <= {FILT_W{1'b0}};
         div_r     <= 4'h0;
         rise_en_r <= {CHANNELS{1'b0}};
         fall_en_r <= {CHANNELS{1'b0}};
      end else begin
         if (ctrl_wr_s) begin
            enable_r <= data_in[0 +: CHANNELS];
            invert_r <= data_in[8 +: CHANNELS];
            thresh_r <= data_in[16 +: FILT_W];
            div_r    <= data_in[23:20];
         end
         if (irqen_wr_s) begin
            rise_en_r <= data_in[0 +: CHANNELS];
            fall_en_r <= data_in[8 +: CHANNELS];
         end
      end
   end

   // Zero-extended register images for readback.
   always_comb begin
      rd_ctrl_s                    = 32'h0000_0000;
      rd_ctrl_s[0 +: CHANNELS]     = enable_r;
      rd_ctrl_s[8 +: CHANNELS]     = invert_r;
      rd_ctrl_s[16 +: FILT_W]      = thresh_r;
      rd_ctrl_s[23:20]             = div_r;
      rd_status_s                  = 32'h0000_0000;
      rd_status_s[0 +: CHANNELS]   = level_r;
      rd_status_s[8 +: CHANNELS]   = rise_sticky_r;
      rd_status_s[16 +: CHANNELS]  = fall_sticky_r;
      rd_irqen_s                   = 32'h0000_0000;
      rd_irqen_s[0 +: CHANNELS]    = rise_en_r;
      rd_irqen_s[8 +: CHANNELS]    = fall_en_r;
   end

   // Read mux: side-effect free and combinational from address.
   always_comb begin
      data_out = 32'h0000_0000;
      case (address)
         ADDR_CTRL:   data_out = rd_ctrl_s;
         ADDR_STATUS: data_out = rd_status_s;
         ADDR_IRQEN:  data_out = rd_irqen_s;
         default:     data_out = 32'h0000_0000;
      endcase
   end

endmodule

// File: tb/tb_tqvp_prism_incond.sv
// Directed bench for tqvp_prism_incond: filter latency, glitch rejection,
// stickies, interrupt, prescaler phase, disable/invert and reset.
module tb_tqvp_prism_incond;

   logic        clk;
   logic        rst_n;
   logic [7:0]  ui_in;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;
   logic [7:0]  cond_level;
   logic [7:0]  cond_rise;
   logic [7:0]  cond_fall;
   logic        irq;

   int checks;
   int failures;

   tqvp_prism_incond #(.CHANNELS(8), .FILT_W(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ui_in        (ui_in),
      .address      (address),
      .data_in      (data_in),
      .data_write_n (data_write_n),
      .data_read_n  (data_read_n),
      .data_out     (data_out),
      .data_ready   (data_ready),
      .cond_level   (cond_level),
      .cond_rise    (cond_rise),
      .cond_fall    (cond_fall),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
      address      = a;
      data_in      = d;
      data_write_n = 2'b10;
      @(negedge clk);
      data_write_n = 2'b11;
      data_in      = 32'h0000_0000;
   endtask

   task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
      address = a;
      #1;
      check(tag, data_out, exp);
   endtask

   task automatic outs(input string tag, input logic [7:0] lvl, input logic [7:0] ri,
                       input logic [7:0] fa, input logic iq);
      check({tag, "_level"}, {24'h0, cond_level}, {24'h0, lvl});
      check({tag, "_rise"},  {24'h0, cond_rise},  {24'h0, ri});
      check({tag, "_fall"},  {24'h0, cond_fall},  {24'h0, fa});
      check({tag, "_irq"},   {31'h0, irq},        {31'h0, iq});
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst_n        = 1'b0;
      ui_in        = 8'h00;
      address      = 6'h00;
      data_in      = 32'h0000_0000;
      data_write_n = 2'b11;
      data_read_n  = 2'b11;

      // Reset state
      cycles(2);
      rst_n = 1'b1;
      cycles(1);
      outs("reset", 8'h00, 8'h00, 8'h00, 1'b0);
      check("data_ready", {31'h0, data_ready}, 32'h1);
      rd("reset_ctrl",   6'h30, 32'h0000_0000);
      rd("reset_status", 6'h34, 32'h0000_0000);
      rd("reset_irqen",  6'h38, 32'h0000_0000);
      rd("unmapped",     6'h3C, 32'h0000_0000);

      // A byte-wide write must be ignored
      address = 6'h38; data_in = 32'h0000_FFFF; data_write_n = 2'b00;
      cycles(1);
      data_write_n = 2'b11;
      rd("byte_write_ignored", 6'h38, 32'h0000_0000);

      // ch0 enabled, thresh 3, div 0; a 2-cycle high glitch is rejected
      bus_wr(6'h30, 32'h0003_0001);
      rd("ctrl_readback", 6'h30, 32'h0003_0001);
      ui_in[0] = 1'b1;
      cycles(2);
      ui_in[0] = 1'b0;
      cycles(3);
      outs("glitch", 8'h00, 8'h00, 8'h00, 1'b0);
      rd("glitch_status", 6'h34, 32'h0000_0000);

      // Steady high: level updates on the third sampling edge
      ui_in[0] = 1'b1;
      cycles(2);
      outs("rise_edge2", 8'h00, 8'h00, 8'h00, 1'b0);
      cycles(1);
      outs("rise_edge3", 8'h01, 8'h01, 8'h00, 1'b0);
      rd("rise_status", 6'h34, 32'h0000_0101);
      cycles(1);
      outs("rise_after", 8'h01, 8'h00, 8'h00, 1'b0);

      // Fall interrupt, then W1C clear
      bus_wr(6'h38, 32'h0000_0100);
      ui_in[0] = 1'b0;
      cycles(2);
      outs("fall_edge2", 8'h01, 8'h00, 8'h00, 1'b0);
      cycles(1);
      outs("fall_edge3", 8'h00, 8'h00, 8'h01, 1'b0);
      rd("fall_status", 6'h34, 32'h0001_0100);
      cycles(1);
      outs("fall_irq", 8'h00, 8'h00, 8'h00, 1'b1);
      bus_wr(6'h34, 32'h0001_0000);
      check("irq_after_clr1", {31'h0, irq}, 32'h1);
      rd("status_after_clr", 6'h34, 32'h0000_0100);
      cycles(1);
      check("irq_after_clr2", {31'h0, irq}, 32'h0);
      bus_wr(6'h34, 32'h0000_0100);
      rd("status_cleared", 6'h34, 32'h0000_0000);

      // div=2, thresh 2, phase aligned by the CTRL write: ticks on edges 4 and 8
      bus_wr(6'h30, 32'h0022_0001);
      ui_in[0] = 1'b1;
      cycles(7);
      outs("div_edge7", 8'h00, 8'h00, 8'h00, 1'b0);
      cycles(1);
      outs("div_edge8", 8'h01, 8'h01, 8'h00, 1'b0);
      bus_wr(6'h34, 32'h0000_FF00);

      // Disabling a high channel drops level silently
      bus_wr(6'h30, 32'h0002_0000);
      cycles(1);
      outs("disable", 8'h00, 8'h00, 8'h00, 1'b0);
      cycles(2);
      outs("disable_later", 8'h00, 8'h00, 8'h00, 1'b0);
      rd("disable_status", 6'h34, 32'h0000_0000);

      // Inverted ch1 with pin low rises after the threshold
      bus_wr(6'h30, 32'h0002_0202);
      cycles(1);
      outs("inv_edge1", 8'h00, 8'h00, 8'h00, 1'b0);
      cycles(1);
      outs("inv_edge2", 8'h02, 8'h02, 8'h00, 1'b0);
      rd("inv_status", 6'h34, 32'h0000_0202);

      // Same-cycle W1C and new rise on ch1: set wins
      ui_in[1] = 1'b1;
      cycles(2);
      outs("ch1_fall", 8'h00, 8'h00, 8'h02, 1'b0);
      ui_in[1] = 1'b0;
      cycles(1);
      bus_wr(6'h34, 32'h0000_0200);
      outs("setwins", 8'h02, 8'h02, 8'h00, 1'b0);
      rd("setwins_status", 6'h34, 32'h0002_0202);

      // Reset mid-count
      ui_in[1] = 1'b1;
      cycles(1);
      rst_n = 1'b0;
      #1;
      outs("async_reset", 8'h00, 8'h00, 8'h00, 1'b0);
      rd("async_reset_ctrl", 6'h30, 32'h0000_0000);
      cycles(1);
      rst_n = 1'b1;
      cycles(3);
      outs("post_reset", 8'h00, 8'h00, 8'h00, 1'b0);
      rd("post_reset_status", 6'h34, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
